// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, data-memory FSM states and the access-fault rule.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Misalignment or an encoding that has no meaning for this direction.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] offset);
        logic fault;
        case (f3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = offset[0];
            F3_W:    fault = (offset != 2'b00);
            F3_BU:   fault = is_store;
            F3_HU:   fault = is_store | offset[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            F3_W:    result = word;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with a three-state request/response handshake
// supporting RV32I byte, half and word loads/stores.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        respValid,
    output logic [31:0] readData,
    output logic        error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t state, state_next;

    logic             req_write;
    logic [2:0]       req_funct3;
    logic [IDX_W+1:0] req_addr;
    logic [31:0]      req_wdata;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      cur_word;
    logic [31:0]      load_word;
    logic [31:0]      store_word;
    logic             fault;
    logic             unused_addr_bits;

    // Upper address bits alias onto the array, so they are never stored.
    assign unused_addr_bits = ^address[31:IDX_W+2];

    assign word_idx  = req_addr[IDX_W+1:2];
    assign cur_word  = mem[word_idx];
    assign fault     = access_fault(req_write, req_funct3, req_addr[1:0]);
    assign reqReady  = (state == IDLE);
    assign respValid = (state == RESP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (reqValid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_write  <= 1'b0;
            req_funct3 <= 3'd0;
            req_addr   <= '0;
            req_wdata  <= 32'd0;
        end else if (reqValid && reqReady) begin
            req_write  <= memWrite;
            req_funct3 <= funct3;
            req_addr   <= address[IDX_W+1:0];
            req_wdata  <= writeData;
        end
    end

    always_comb begin
        store_word = cur_word;
        case (req_funct3)
            F3_B:    store_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
            F3_H:    store_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
            F3_W:    store_word = req_wdata;
            default: store_word = cur_word;
        endcase
    end

    // Reset forces IDLE asynchronously, so a store caught in ACCESS never commits.
    always_ff @(posedge clock) begin
        if (state == ACCESS && req_write && !fault) begin
            mem[word_idx] <= store_word;
        end
    end

    load_extend u_load_extend (
        .funct3 (req_funct3),
        .offset (req_addr[1:0]),
        .word   (cur_word),
        .result (load_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readData <= 32'd0;
            error    <= 1'b0;
        end else if (state == ACCESS) begin
            readData <= (req_write || fault) ? 32'd0 : load_word;
            error    <= fault;
        end else begin
            readData <= 32'd0;
            error    <= 1'b0;
        end
    end

endmodule
